// File: rtl/pmu_power_button.sv
// Board-side power button / regulator-enable controller for the PMU interface.
// Optional PMU acknowledge timeout is compiled in with `define KILL_TIMEOUT_EN.
module pmu_power_button #(
    parameter int unsigned CLOCK_FREQUENCE    = 300000000,
    parameter int unsigned DEBOUNCE_CYCLES    = 3000000,
    parameter int unsigned LONGPRESS_CYCLES   = 1200000000,
    parameter int unsigned POWERKILL_DELAY    = 300000000,
    parameter int unsigned INT_PULSE_CYCLES   = 300,
    parameter int unsigned ACK_TIMEOUT_CYCLES = 1500000000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       BUTTON_N,
    input  logic       KILL_POWER,
    output logic       POWER_INT,
    output logic       POWER_EN,
    output logic [1:0] STATE
);

    localparam int unsigned CNT_W = 32;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_MAX   = CNT_W'(LONGPRESS_CYCLES);
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(LONGPRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(POWERKILL_DELAY - 1);
    localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_PULSE_CYCLES - 1);

    // Every "-1" above relies on nonzero timing parameters.
    if (CLOCK_FREQUENCE == 0 || DEBOUNCE_CYCLES == 0 || LONGPRESS_CYCLES == 0 ||
        POWERKILL_DELAY == 0 || INT_PULSE_CYCLES == 0 || ACK_TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("pmu_power_button: timing parameters must be nonzero");
    end

    typedef enum logic [1:0] {
        ST_ON        = 2'd0,
        ST_KILL_WAIT = 2'd1,
        ST_OFF       = 2'd2
    } state_e;

    logic [1:0]       btn_sync_q;
    logic [1:0]       kill_sync_q;
    logic             kill_prev_q;
    logic             btn_db_q;
    logic             btn_db_prev_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] lp_cnt_q;

    state_e           state_q;
    logic [CNT_W-1:0] dly_cnt_q;
    logic [CNT_W-1:0] int_cnt_q;
    logic             power_int_q;
    logic             power_en_q;

    logic pressed_s;
    logic kill_s;
    logic press_edge;
    logic kill_edge;
    logic lp_hit;
    logic timeout_hit;
    logic leave_on;

    assign pressed_s  = btn_sync_q[1];
    assign kill_s     = kill_sync_q[1];
    assign press_edge = btn_db_q & ~btn_db_prev_q;
    assign kill_edge  = kill_s & ~kill_prev_q;
    assign lp_hit     = btn_db_q && (lp_cnt_q == LP_LAST);
    assign leave_on   = (state_q == ST_ON) && (lp_hit || kill_edge || timeout_hit);

    // Synchronizers, debounce and long-press counter.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            btn_sync_q    <= '0;
            kill_sync_q   <= '0;
            kill_prev_q   <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            lp_cnt_q      <= '0;
        end else begin
            btn_sync_q    <= {btn_sync_q[0], ~BUTTON_N};
            kill_sync_q   <= {kill_sync_q[0], KILL_POWER};
            kill_prev_q   <= kill_s;
            btn_db_prev_q <= btn_db_q;

            // The update lands on the cycle the stable count would reach DEBOUNCE_CYCLES.
            if (pressed_s == btn_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                btn_db_q <= pressed_s;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + CNT_W'(1);
            end

            if (!btn_db_q) begin
                lp_cnt_q <= '0;
            end else if (lp_cnt_q != LP_MAX) begin
                lp_cnt_q <= lp_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef KILL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] ack_cnt_q;
    logic             ack_run_q;

    assign timeout_hit = ack_run_q && (state_q == ST_ON) && (ack_cnt_q == ACK_LAST);

    // Shut down on our own if the PMU never answers a press.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ack_cnt_q <= '0;
            ack_run_q <= 1'b0;
        end else if (state_q != ST_ON || leave_on) begin
            ack_cnt_q <= '0;
            ack_run_q <= 1'b0;
        end else if (press_edge) begin
            ack_cnt_q <= '0;
            ack_run_q <= 1'b1;
        end else if (ack_run_q) begin
            ack_cnt_q <= ack_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Power FSM with registered POWER_INT / POWER_EN.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= ST_ON;
            dly_cnt_q   <= '0;
            int_cnt_q   <= '0;
            power_int_q <= 1'b0;
            power_en_q  <= 1'b1;
        end else begin
            power_en_q <= (state_q != ST_OFF);

            case (state_q)
                ST_ON: begin
                    if (lp_hit) begin
                        state_q <= ST_OFF;
                    end else if (kill_edge || timeout_hit) begin
                        state_q   <= ST_KILL_WAIT;
                        dly_cnt_q <= '0;
                    end
                end
                ST_KILL_WAIT: begin
                    if (lp_hit || dly_cnt_q == DLY_LAST) begin
                        state_q <= ST_OFF;
                    end else begin
                        dly_cnt_q <= dly_cnt_q + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (press_edge) begin
                        state_q <= ST_ON;
                    end
                end
                default: state_q <= ST_ON;
            endcase

            // int_cnt_q holds the pulse cycles still owed after the current one.
            if (state_q != ST_ON || leave_on) begin
                int_cnt_q   <= '0;
                power_int_q <= 1'b0;
            end else if (press_edge) begin
                int_cnt_q   <= INT_LAST;
                power_int_q <= 1'b1;
            end else if (int_cnt_q != '0) begin
                int_cnt_q   <= int_cnt_q - CNT_W'(1);
                power_int_q <= 1'b1;
            end else begin
                power_int_q <= 1'b0;
            end
        end
    end

    assign POWER_INT = power_int_q;
    assign POWER_EN  = power_en_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_pmu_power_button.sv
// Directed self-checking bench for pmu_power_button with short timing parameters.
module tb_pmu_power_button;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       BUTTON_N;
    logic       KILL_POWER;
    logic       POWER_INT;
    logic       POWER_EN;
    logic [1:0] STATE;

    int n_checks = 0;
    int n_errors = 0;

    pmu_power_button #(
        .CLOCK_FREQUENCE   (100),
        .DEBOUNCE_CYCLES   (4),
        .LONGPRESS_CYCLES  (20),
        .POWERKILL_DELAY   (10),
        .INT_PULSE_CYCLES  (3),
        .ACK_TIMEOUT_CYCLES(30)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .BUTTON_N  (BUTTON_N),
        .KILL_POWER(KILL_POWER),
        .POWER_INT (POWER_INT),
        .POWER_EN  (POWER_EN),
        .STATE     (STATE)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 2 ns after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLOCK);
        #2;
    endtask

    // Fresh 8-cycle press from OFF: ON 7 edges after the fall, POWER_EN one edge later.
    task automatic repower(input string tag);
        BUTTON_N = 1'b0;
        step(6);
        check({tag, "_still_off"}, 32'(STATE), 2);
        step(1);
        check({tag, "_state_on"}, 32'(STATE), 0);
        check({tag, "_en_lag"}, 32'(POWER_EN), 0);
        step(1);
        check({tag, "_en_on"}, 32'(POWER_EN), 1);
        check({tag, "_no_int"}, 32'(POWER_INT), 0);
        BUTTON_N = 1'b1;
        step(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RESET      = 1'b1;
        BUTTON_N   = 1'b1;
        KILL_POWER = 1'b0;
        step(3);
        check("rst_en", 32'(POWER_EN), 1);
        check("rst_int", 32'(POWER_INT), 0);
        check("rst_state", 32'(STATE), 0);
        RESET = 1'b0;
        step(5);
        check("idle_en", 32'(POWER_EN), 1);
        check("idle_state", 32'(STATE), 0);

        // 3-cycle glitch must never be accepted.
        BUTTON_N = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check("glitch_int", 32'(POWER_INT), 0);
            if (k == 3) BUTTON_N = 1'b1;
        end
        check("glitch_state", 32'(STATE), 0);

        // 8-cycle press: POWER_INT high on edges 7..9 after the fall.
        BUTTON_N = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check("press_int", 32'(POWER_INT), 32'(k >= 7 && k <= 9));
            if (k == 8) BUTTON_N = 1'b1;
        end
        step(10);

        // Kill request held through the commit delay.
        KILL_POWER = 1'b1;
        step(2);
        check("kill_state_pre", 32'(STATE), 0);
        step(1);
        check("kill_state_wait", 32'(STATE), 1);
        step(9);
        check("kill_state_last", 32'(STATE), 1);
        check("kill_en_last", 32'(POWER_EN), 1);
        step(1);
        check("kill_state_off", 32'(STATE), 2);
        check("kill_en_lag", 32'(POWER_EN), 1);
        step(1);
        check("kill_en_off", 32'(POWER_EN), 0);
        check("kill_int", 32'(POWER_INT), 0);

        // Re-power with KILL_POWER still high: no fresh edge, so stay ON.
        repower("rp_kill_high");
        step(20);
        check("kill_held_state", 32'(STATE), 0);
        check("kill_held_en", 32'(POWER_EN), 1);
        KILL_POWER = 1'b0;
        step(5);

        // Kill request dropped mid-wait is still committed.
        KILL_POWER = 1'b1;
        step(3);
        check("drop_state_wait", 32'(STATE), 1);
        step(2);
        KILL_POWER = 1'b0;
        step(8);
        check("drop_state_off", 32'(STATE), 2);
        step(1);
        check("drop_en_off", 32'(POWER_EN), 0);
        repower("rp_drop");

        // Long press: one pulse, OFF 26 edges after the fall, POWER_EN low at 27.
        BUTTON_N = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            check("lp_int", 32'(POWER_INT), 32'(k >= 7 && k <= 9));
            check("lp_state", 32'(STATE), (k >= 26) ? 2 : 0);
            check("lp_en", 32'(POWER_EN), 32'(k < 27));
            if (k == 40) BUTTON_N = 1'b1;
        end
        step(15);
        check("lp_release_state", 32'(STATE), 2);
        repower("rp_lp");

        // kill_edge coincides with lp_hit: straight to OFF.
        BUTTON_N = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            check("sim_state", 32'(STATE), (k >= 26) ? 2 : 0);
            if (k == 23) KILL_POWER = 1'b1;
            if (k == 30) BUTTON_N = 1'b1;
        end
        step(15);
        KILL_POWER = 1'b0;
        step(5);
        repower("rp_sim");

        // Press with no PMU response.
        BUTTON_N = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step(1);
            if (k == 8) BUTTON_N = 1'b1;
`ifdef KILL_TIMEOUT_EN
            if (k == 36) check("to_state_pre", 32'(STATE), 0);
            if (k == 37) check("to_state_wait", 32'(STATE), 1);
            if (k == 46) check("to_state_last", 32'(STATE), 1);
            if (k == 47) check("to_state_off", 32'(STATE), 2);
            if (k == 48) check("to_en_off", 32'(POWER_EN), 0);
`else
            if (k == 37) check("noto_state", 32'(STATE), 0);
            if (k == 50) check("noto_en", 32'(POWER_EN), 1);
`endif
        end
`ifdef KILL_TIMEOUT_EN
        step(5);
        repower("rp_to");
`else
        step(50);
        check("noto_state_late", 32'(STATE), 0);
`endif

        // Reset in the middle of KILL_WAIT.
        KILL_POWER = 1'b1;
        step(5);
        check("mid_state_wait", 32'(STATE), 1);
        RESET      = 1'b1;
        KILL_POWER = 1'b0;
        step(1);
        check("mid_rst_state", 32'(STATE), 0);
        check("mid_rst_en", 32'(POWER_EN), 1);
        check("mid_rst_int", 32'(POWER_INT), 0);
        RESET = 1'b0;
        step(20);
        check("mid_after_state", 32'(STATE), 0);
        check("mid_after_en", 32'(POWER_EN), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
